// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: ALU-side capture port and consumer-side valid/ready port of alu_result_fifo
// slave is the FIFO's view; master is the view of whatever drives the ALU side and consumes results.
interface alu_result_fifo_if #(
    parameter int N     = 64,
    parameter int DEPTH = 4
);
    logic                     i_valid;
    logic                     o_ready;
    logic [N-1:0]             i_result;
    logic                     i_carry_out;
    logic [1:0]               i_alu_ctrl;
    logic                     i_a_msb;
    logic                     i_b_msb;
    logic                     o_valid;
    logic                     i_ready;
    logic [N-1:0]             o_result;
    logic [3:0]               o_flags;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     i_clr_sticky;
    logic                     o_sticky_ovf;

    modport slave (
        input  i_valid, i_result, i_carry_out, i_alu_ctrl, i_a_msb, i_b_msb, i_ready, i_clr_sticky,
        output o_ready, o_valid, o_result, o_flags, o_count, o_sticky_ovf
    );

    modport master (
        output i_valid, i_result, i_carry_out, i_alu_ctrl, i_a_msb, i_b_msb, i_ready, i_clr_sticky,
        input  o_ready, o_valid, o_result, o_flags, o_count, o_sticky_ovf
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers ALU results with {N,Z,C,V} flags behind a valid/ready handshake
// Optional sticky overflow flag enabled by defining ALU_RESULT_FIFO_STICKY_OVF_EN.
module alu_result_fifo #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    alu_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N+3:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;
    logic          res_msb;

    assign bus.o_valid = (count != '0);
    assign bus.o_ready = (count != CW'(DEPTH));
    assign bus.o_count = count;
    assign push        = bus.i_valid & bus.o_ready;
    assign pop         = bus.o_valid & bus.i_ready;

    always_comb begin
        res_msb = bus.i_result[N-1];
        flag_n  = res_msb;
        flag_z  = (bus.i_result == '0);
        flag_c  = bus.i_alu_ctrl[1] ? 1'b0 : bus.i_carry_out;
        flag_v  = (bus.i_alu_ctrl == 2'b00) ? ((bus.i_a_msb == bus.i_b_msb) & (res_msb != bus.i_a_msb)) :
                  (bus.i_alu_ctrl == 2'b01) ? ((bus.i_a_msb != bus.i_b_msb) & (res_msb != bus.i_a_msb)) :
                  1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {bus.i_result, flag_n, flag_z, flag_c, flag_v};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Zero the head when empty so stale storage never leaks to the consumer.
    assign bus.o_result = bus.o_valid ? mem[rd_ptr][N+3:4] : '0;
    assign bus.o_flags  = bus.o_valid ? mem[rd_ptr][3:0]   : '0;

`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    logic sticky_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            sticky_ovf <= 1'b0;
        else if (push & flag_v)
            sticky_ovf <= 1'b1;
        else if (bus.i_clr_sticky)
            sticky_ovf <= 1'b0;
    end

    assign bus.o_sticky_ovf = sticky_ovf;
`else
    logic unused_clr;

    assign unused_clr       = bus.i_clr_sticky;
    assign bus.o_sticky_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed vectors with hand-computed results and flags for alu_result_fifo
// Sticky expectations follow ALU_RESULT_FIFO_STICKY_OVF_EN.
module tb_alu_result_fifo;
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_result_fifo_if #(.N(8), .DEPTH(4)) bus ();

    alu_result_fifo #(.N(8), .DEPTH(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic c, input logic [1:0] op, input logic a, input logic b);
        bus.i_result    = r;
        bus.i_carry_out = c;
        bus.i_alu_ctrl  = op;
        bus.i_a_msb     = a;
        bus.i_b_msb     = b;
    endtask

    task automatic push(input logic [7:0] r, input logic c, input logic [1:0] op, input logic a, input logic b);
        drive(r, c, op, a, b);
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic pop();
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
    endtask

    task automatic head(input string tag, input logic [7:0] r, input logic [3:0] f);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_res"}, 32'(bus.o_result), 32'(r));
        check({tag, "_flags"}, 32'(bus.o_flags), 32'(f));
    endtask

    initial begin
        bus.i_ready      = 1'b0;
        bus.i_clr_sticky = 1'b0;
        drive(8'h99, 1'b1, 2'b00, 1'b1, 1'b1);
        bus.i_valid = 1'b1;
        step();
        step();
        i_rst_n     = 1'b1;
        bus.i_valid = 1'b0;
        step();
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_res", 32'(bus.o_result), 32'd0);
        check("rst_flags", 32'(bus.o_flags), 32'd0);
        check("rst_sticky", 32'(bus.o_sticky_ovf), 32'd0);

        // add 0x7F+0x01: no same-cycle bypass, visible one edge later
        drive(8'h80, 1'b0, 2'b00, 1'b0, 1'b0);
        bus.i_valid = 1'b1;
        check("nobypass", 32'(bus.o_valid), 32'd0);
        step();
        bus.i_valid = 1'b0;
        head("add_ovf", 8'h80, 4'b1001);
        check("add_sticky", 32'(bus.o_sticky_ovf), 32'(STICKY_EN));
        bus.i_clr_sticky = 1'b1;
        pop();
        bus.i_clr_sticky = 1'b0;
        check("pop_empty", 32'(bus.o_valid), 32'd0);
        check("clr_sticky0", 32'(bus.o_sticky_ovf), 32'd0);

        push(8'h00, 1'b1, 2'b01, 1'b0, 1'b0);
        head("sub_zero", 8'h00, 4'b0110);
        pop();
        push(8'hFF, 1'b1, 2'b11, 1'b1, 1'b0);
        head("or_ff", 8'hFF, 4'b1000);
        pop();
        push(8'h00, 1'b1, 2'b00, 1'b1, 1'b1);
        head("add_neg_ovf", 8'h00, 4'b0111);
        pop();
        check("ovf_sticky1", 32'(bus.o_sticky_ovf), 32'(STICKY_EN));
        bus.i_clr_sticky = 1'b1;
        step();
        bus.i_clr_sticky = 1'b0;
        check("clr_sticky1", 32'(bus.o_sticky_ovf), 32'd0);

        // sub 0x80-0x01 overflows; clear in the same cycle must lose
        push(8'h7F, 1'b1, 2'b01, 1'b1, 1'b0);
        head("sub_ovf", 8'h7F, 4'b0011);
        check("sub_sticky", 32'(bus.o_sticky_ovf), 32'(STICKY_EN));
        pop();
        bus.i_clr_sticky = 1'b1;
        push(8'h7F, 1'b1, 2'b01, 1'b1, 1'b0);
        bus.i_clr_sticky = 1'b0;
        check("clr_vs_set", 32'(bus.o_sticky_ovf), 32'(STICKY_EN));
        pop();

        push(8'h11, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'h22, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'h33, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'h44, 1'b0, 2'b10, 1'b0, 1'b0);
        check("full_count", 32'(bus.o_count), 32'd4);
        check("full_ready", 32'(bus.o_ready), 32'd0);
        push(8'h55, 1'b1, 2'b00, 1'b0, 1'b0);
        check("drop_count", 32'(bus.o_count), 32'd4);
        head("stable", 8'h11, 4'b0000);
        bus.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_res", 32'(bus.o_result), 32'(8'h11 * (k + 1)));
            step();
            check("drain_ready", 32'(bus.o_ready), 32'd1);
        end
        bus.i_ready = 1'b0;
        check("drain_valid", 32'(bus.o_valid), 32'd0);
        check("drain_count", 32'(bus.o_count), 32'd0);

        push(8'hA0, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'hA1, 1'b0, 2'b10, 1'b0, 1'b0);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(8'(8'hA2 + k), 1'b0, 2'b10, 1'b0, 1'b0);
            check("pp_head", 32'(bus.o_result), 32'(8'hA0 + k));
            step();
            check("pp_count", 32'(bus.o_count), 32'd2);
        end
        bus.i_valid = 1'b0;
        check("pp_tail0", 32'(bus.o_result), 32'h0A6);
        step();
        check("pp_tail1", 32'(bus.o_result), 32'h0A7);
        step();
        bus.i_ready = 1'b0;
        check("pp_empty", 32'(bus.o_valid), 32'd0);

        push(8'hB1, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'hB2, 1'b0, 2'b10, 1'b0, 1'b0);
        push(8'hB3, 1'b0, 2'b10, 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.o_count), 32'd3);
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check("mid_rst_count", 32'(bus.o_count), 32'd0);
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_sticky", 32'(bus.o_sticky_ovf), 32'd0);
        push(8'hC1, 1'b0, 2'b10, 1'b0, 1'b0);
        head("post_rst", 8'hC1, 4'b1000);
        check("post_rst_count", 32'(bus.o_count), 32'd1);
        pop();
        check("post_rst_empty", 32'(bus.o_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
